longmultiplier: RTL and testbench
=================================

Name: longmultiplier

Overview:
- Sequential shift-and-add multiply-accumulate that computes P = A*B + R. It is the inverse operation of the long divider: quotient, divisor and remainder go in, the original dividend comes out.
- Used as a companion checker/reconstructor beside longdivider.
- Uses the same control style as longdivider: load enables, start pulse `s`, `Done` flag, and an idle/compute/done ASM.

Parameters:
- N, 8, operand width in bits; product/result width is 2N.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- s  input  1  start; sampled only in state S1.
- LA  input  1  load enable for operand A register (multiplier, the quotient).
- EB  input  1  load enable for operand B register (multiplicand, the divisor).
- ER  input  1  load enable for addend R register (the remainder).
- DataA  input  N  multiplier data.
- DataB  input  N  multiplicand data.
- DataR  input  N  addend data.
- P  output  2N  result register A*B + R.
- Done  output  1  high while in state S3; P is valid.

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state <= S1.
  - A, B, R operand registers, working registers, counter and P all <= 0.
  - Done = 0.
- Reset asserted mid-computation aborts the operation; no partial result is kept.
- Operand registers (S1 only):
  - In S1, LA/EB/ER each load DataA/DataB/DataR independently on the rising edge.
  - In S2 and S3, LA/EB/ER are ignored.
  - Operand registers are never modified by the computation, so re-pulsing `s` recomputes with the same operands.
- State machine:
  - S1 (idle): if s=1 at the edge, then:
    - state <= S2;
    - P <= zero-extended R;
    - working multiplier WA <= A;
    - working multiplicand WB (2N bits) <= zero-extended B;
    - count <= N-1.
    - If LA/EB/ER and s are both high in the same S1 cycle, the operand load and the start happen together. The start uses the old register values; the new values are available for the next run.
  - S2 (compute), one iteration per edge:
    - if WA[0]=1, P <= P + WB (2N-bit add);
    - WA <= WA >> 1;
    - WB <= WB << 1;
    - count <= count - 1.
    - When count=0 at the edge, the final iteration is performed and state <= S3.
    - s is ignored in S2.
  - S3 (done): Done=1 and P holds.
    - If s=1, remain in S3.
    - If s=0, state <= S1 at the next edge. P is retained in S1 until the next start or reset.
- Latency:
  - The edge that samples s=1 in S1 is E0. Done goes high after edge E0+N.
  - With s dropped before E0+N, Done is a one-cycle pulse and the block is idle again at E0+N+1.
- Arithmetic/width:
  - Max result is (2^N-1)^2 + (2^N-1) = 2^2N - 2^N, which is < 2^2N, so no overflow is possible.
  - Unsigned only; no overflow flag.
  - A = 0 or B = 0 yields P = R.
- Done is a combinational decode of state==S3; no glitching outside S3.

Test Plan:
- Basic inverse of the divider case: reset; in S1 load DataA=8'h07, DataB=8'h02, DataR=8'h01 with LA=EB=ER=1; next cycle s=1 for one cycle -> Done rises exactly N=8 edges after the s-sampling edge, P=16'h000F, and Done is high for exactly one cycle.
- Extremes: A=8'hFF, B=8'hFF, R=8'hFF -> P=16'hFF00. A=0, B=8'h5A, R=8'h3C -> P=16'h003C. A=8'h80, B=8'h01, R=0 -> P=16'h0080.
- Held start: s kept high through completion -> Done stays 1 and P is stable until s=0, then the block returns to S1 one edge later; a second s pulse without reloading gives the same P.
- Load ignored while busy: during S2, assert LA=1 with DataA=8'hAA -> result uses the original A. After return to S1, a rerun without reloading still gives the original result, confirming the A register was not updated.
- Reset mid-operation: assert Reset at the 4th compute edge -> next edge P=0, Done=0, state S1. A subsequent load/start of 12*11+5 -> P=16'h0089.
- Back-to-back: after Done, drop s for one cycle, reload A=8'h0D, B=8'h03, R=8'h02, start -> P=16'h0029 with correct N-edge latency.

Source files
------------

// File: rtl/longmultiplier_if.sv
// Operand/control/result bundle for the shift-and-add multiply-accumulate unit.
// master drives operands and start; slave returns the result and Done.
interface longmultiplier_if #(
  parameter int N = 8
);
  logic           s;
  logic           LA;
  logic           EB;
  logic           ER;
  logic [N-1:0]   DataA;
  logic [N-1:0]   DataB;
  logic [N-1:0]   DataR;
  logic [2*N-1:0] P;
  logic           Done;

  modport master (
    output s, LA, EB, ER, DataA, DataB, DataR,
    input  P, Done
  );

  modport slave (
    input  s, LA, EB, ER, DataA, DataB, DataR,
    output P, Done
  );
endinterface

// File: rtl/longmultiplier.sv
// Sequential shift-and-add multiply-accumulate: P = A*B + R, the inverse of longdivider.
// One partial product per clock in S2; Done decodes S3.
module longmultiplier #(
  parameter int N = 8
) (
  input logic             Clock,
  input logic             Reset,
  longmultiplier_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S1 = 2'd0;
  localparam logic [1:0] S2 = 2'd1;
  localparam logic [1:0] S3 = 2'd2;

  logic [1:0]     state;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [N-1:0]   r_reg;
  logic [N-1:0]   wa;
  logic [2*N-1:0] wb;
  logic [2*N-1:0] p_reg;
  logic [CW-1:0]  count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S1;
      a_reg <= '0;
      b_reg <= '0;
      r_reg <= '0;
      wa    <= '0;
      wb    <= '0;
      p_reg <= '0;
      count <= '0;
    end else begin
      case (state)
        S1: begin
          if (bus.LA) a_reg <= bus.DataA;
          if (bus.EB) b_reg <= bus.DataB;
          if (bus.ER) r_reg <= bus.DataR;
          // Start samples the pre-load register values; a simultaneous load feeds the next run.
          if (bus.s) begin
            state <= S2;
            p_reg <= {{N{1'b0}}, r_reg};
            wa    <= a_reg;
            wb    <= {{N{1'b0}}, b_reg};
            count <= CW'(N - 1);
          end
        end
        S2: begin
          if (wa[0]) p_reg <= p_reg + wb;
          wa    <= wa >> 1;
          wb    <= wb << 1;
          count <= count - 1'b1;
          if (count == '0) state <= S3;
        end
        S3: begin
          if (!bus.s) state <= S1;
        end
        default: state <= S1;
      endcase
    end
  end

  assign bus.P    = p_reg;
  assign bus.Done = (state == S3);
endmodule

// File: tb/tb_longmultiplier.sv
// Self-checking bench for longmultiplier: directed cases plus random operands,
// checked against an arithmetic A*B+R model of the operand registers.
module tb_longmultiplier;
  localparam int N = 8;

  logic Clock;
  logic Reset;
  int   n_cmp;
  int   n_err;

  // Model of the architectural operand registers.
  logic [N-1:0] ma, mb, mr;

  longmultiplier_if #(.N(N)) bus ();

  longmultiplier #(.N(N)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [2*N-1:0] mac(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [N-1:0] r);
    int unsigned prod;
    prod = int'(a) * int'(b) + int'(r);
    return prod[2*N-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] r);
    bus.LA = 1'b1; bus.EB = 1'b1; bus.ER = 1'b1;
    bus.DataA = a; bus.DataB = b; bus.DataR = r;
    @(negedge Clock);
    bus.LA = 1'b0; bus.EB = 1'b0; bus.ER = 1'b0;
    ma = a; mb = b; mr = r;
  endtask

  task automatic start_pulse();
    bus.s = 1'b1;
    @(negedge Clock);
  endtask

  // Called one negedge after the s-sampling edge; counts edges until Done.
  task automatic wait_done(input string tag, input logic [2*N-1:0] exp,
                           input bit hold, input bit poke);
    int k;
    k = 0;
    check({tag, "_busy"}, 32'(bus.Done), 32'd0);
    if (!hold) bus.s = 1'b0;
    while (!bus.Done && k < N + 4) begin
      @(negedge Clock);
      k++;
      if (poke) begin
        bus.DataA = 8'hAA;
        bus.LA    = (k == 2);
      end
    end
    bus.LA = 1'b0;
    check({tag, "_lat"}, 32'(k), 32'(N));
    check({tag, "_p"}, 32'(bus.P), 32'(exp));
    if (!hold) begin
      @(negedge Clock);
      check({tag, "_pulse"}, 32'(bus.Done), 32'd0);
    end
  endtask

  task automatic run(input string tag);
    start_pulse();
    wait_done(tag, mac(ma, mb, mr), 1'b0, 1'b0);
  endtask

  initial begin
    logic [2*N-1:0] exp;
    n_cmp = 0; n_err = 0;
    ma = '0; mb = '0; mr = '0;
    bus.s = 1'b0; bus.LA = 1'b0; bus.EB = 1'b0; bus.ER = 1'b0;
    bus.DataA = '0; bus.DataB = '0; bus.DataR = '0;
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    check("rst_p", 32'(bus.P), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    Reset = 1'b0;

    // Basic divider inverse: 7*2+1.
    load(8'h07, 8'h02, 8'h01);
    run("basic");
    check("basic_lit", 32'(bus.P), 32'h000F);

    // Extremes.
    load(8'hFF, 8'hFF, 8'hFF); run("max");   check("max_lit", 32'(bus.P), 32'hFF00);
    load(8'h00, 8'h5A, 8'h3C); run("azero"); check("azero_lit", 32'(bus.P), 32'h003C);
    load(8'h80, 8'h01, 8'h00); run("msb");   check("msb_lit", 32'(bus.P), 32'h0080);
    load(8'h5A, 8'h00, 8'h11); run("bzero");

    // Held start: Done persists until s drops, then S1 one edge later with P retained.
    load(8'h13, 8'h09, 8'h04);
    exp = mac(ma, mb, mr);
    start_pulse();
    wait_done("hold", exp, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("hold_done", 32'(bus.Done), 32'd1);
      check("hold_p", 32'(bus.P), 32'(exp));
    end
    bus.s = 1'b0;
    @(negedge Clock);
    check("hold_exit", 32'(bus.Done), 32'd0);
    check("hold_keep", 32'(bus.P), 32'(exp));
    run("rerun");

    // Load attempt while busy must be ignored.
    load(8'h33, 8'h05, 8'h07);
    start_pulse();
    wait_done("busyld", mac(ma, mb, mr), 1'b0, 1'b1);
    run("busyld_rerun");

    // Load together with start: run uses old operands, next run the new ones.
    load(8'h21, 8'h03, 8'h02);
    exp = mac(ma, mb, mr);
    bus.LA = 1'b1; bus.EB = 1'b1; bus.ER = 1'b1;
    bus.DataA = 8'h0A; bus.DataB = 8'h0B; bus.DataR = 8'h0C;
    start_pulse();
    bus.LA = 1'b0; bus.EB = 1'b0; bus.ER = 1'b0;
    wait_done("ldstart", exp, 1'b0, 1'b0);
    ma = 8'h0A; mb = 8'h0B; mr = 8'h0C;
    run("ldstart_next");

    // Reset at the 4th compute edge aborts and clears everything.
    load(8'h77, 8'h66, 8'h55);
    start_pulse();
    bus.s = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_p", 32'(bus.P), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    ma = '0; mb = '0; mr = '0;
    @(negedge Clock);
    check("abort_idle", 32'(bus.Done), 32'd0);
    run("abort_zero_ops");
    load(8'd12, 8'd11, 8'd5); run("post_abort"); check("post_abort_lit", 32'(bus.P), 32'h0089);

    // Back-to-back: drop s one cycle, reload, restart.
    @(negedge Clock);
    load(8'h0D, 8'h03, 8'h02); run("b2b"); check("b2b_lit", 32'(bus.P), 32'h0029);

    // Random operands.
    for (int unsigned i = 0; i < 12; i++) begin
      load(N'($urandom), N'($urandom), N'($urandom));
      run("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
